// File: rtl/xm_shifter_pkg.sv
// Shared types for the iterative shifter.
//   shift_op_e   : operation codes (codes above OP_PASS also behave as PASS)
//   status_bit_e : bit positions inside the 4-bit status word
//   state_e      : controller state encoding
package xm_shifter_pkg;

  typedef enum logic [2:0] {
    OP_SRA  = 3'd0,
    OP_RRC  = 3'd1,
    OP_SRL  = 3'd2,
    OP_SLL  = 3'd3,
    OP_RLC  = 3'd4,
    OP_PASS = 3'd5
  } shift_op_e;

  typedef enum logic [1:0] {
    FLAG_C = 2'd0,
    FLAG_Z = 2'd1,
    FLAG_N = 2'd2,
    FLAG_V = 2'd3
  } status_bit_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the iterative shifter: applies the selected
// operation k times (k <= STEP) to a data word and its carry.
//   i_op   : operation code (PASS codes leave data and carry untouched)
//   i_k    : number of bit positions for this step, 0..STEP
//   i_data : data word in
//   i_c    : carry in
//   o_data : data word out
//   o_c    : carry out (last bit shifted/rotated out)
module shift_step
  import xm_shifter_pkg::*;
#(
  parameter int WORD = 16,
  parameter int STEP = 1,
  parameter int CW   = $clog2(WORD)
) (
  input  logic [2:0]      i_op,
  input  logic [CW-1:0]   i_k,
  input  logic [WORD-1:0] i_data,
  input  logic            i_c,
  output logic [WORD-1:0] o_data,
  output logic            o_c
);

  logic [WORD-1:0] w_d;
  logic            w_c;
  logic            w_nc;

  // Unrolled chain of STEP single-bit stages; stages at or beyond i_k pass through.
  always_comb begin
    w_d  = i_data;
    w_c  = i_c;
    w_nc = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(i_k)) begin
        case (i_op)
          OP_SRA: begin
            w_c = w_d[0];
            w_d = {w_d[WORD-1], w_d[WORD-1:1]};
          end
          OP_RRC: begin
            w_nc = w_d[0];
            w_d  = {w_c, w_d[WORD-1:1]};
            w_c  = w_nc;
          end
          OP_SRL: begin
            w_c = w_d[0];
            w_d = {1'b0, w_d[WORD-1:1]};
          end
          OP_SLL: begin
            w_c = w_d[WORD-1];
            w_d = {w_d[WORD-2:0], 1'b0};
          end
          OP_RLC: begin
            w_nc = w_d[WORD-1];
            w_d  = {w_d[WORD-2:0], w_c};
            w_c  = w_nc;
          end
          default: ;
        endcase
      end
    end
    o_data = w_d;
    o_c    = w_c;
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts/rotates an operand by up to STEP positions per
// clock until the requested count is exhausted, then presents the result and
// updated flags with a one-cycle done pulse.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, accepted only while idle
//   operation   : 0 SRA, 1 RRC, 2 SRL, 3 SLL, 4 RLC, 5-7 PASS
//   shift       : shift count 0..WORD-1
//   in          : operand
//   status_old  : incoming flags {V,N,Z,C}
//   busy        : controller not idle
//   done        : result valid pulse
//   out         : result, held until the next accepted start
//   status_new  : result flags {V,N,Z,C}, held with out
module iter_shifter
  import xm_shifter_pkg::*;
#(
  parameter int WORD = 16,
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               operation,
  input  logic [$clog2(WORD)-1:0]  shift,
  input  logic [WORD-1:0]          in,
  input  logic [3:0]               status_old,
  output logic                     busy,
  output logic                     done,
  output logic [WORD-1:0]          out,
  output logic [3:0]               status_new
);

  localparam int CW = $clog2(WORD);
  localparam logic [CW-1:0] STEP_W = CW'(STEP);

  state_e          r_state;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_rem;
  logic [WORD-1:0] r_data;
  logic            r_c;
  logic            r_v;
  logic [WORD-1:0] r_out;
  logic [3:0]      r_status;

  logic [CW-1:0]   w_k;
  logic [WORD-1:0] w_data;
  logic            w_c;
  logic [3:0]      w_flags;

  assign w_k = (r_rem > STEP_W) ? STEP_W : r_rem;

  shift_step #(
    .WORD(WORD),
    .STEP(STEP)
  ) u_step (
    .i_op  (r_op),
    .i_k   (w_k),
    .i_data(r_data),
    .i_c   (r_c),
    .o_data(w_data),
    .o_c   (w_c)
  );

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_Z] = (w_data == '0);
    w_flags[FLAG_N] = w_data[WORD-1];
    w_flags[FLAG_V] = r_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rem    <= '0;
      r_data   <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_out    <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= operation;
            r_rem  <= shift;
            r_data <= in;
            r_c    <= status_old[FLAG_C];
            r_v    <= status_old[FLAG_V];
            // Zero count and PASS bypass the RUN state entirely.
            if ((shift == '0) || (operation >= OP_PASS)) begin
              r_out    <= in;
              r_status <= status_old;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_data <= w_data;
          r_c    <= w_c;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_out    <= w_data;
            r_status <= w_flags;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign out        = r_out;
  assign status_new = r_status;

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  sh = '0;
  logic [15:0] din = '0;
  logic [3:0]  sold = '0;
  logic        busy1, done1, busy4, done4;
  logic [15:0] out1, out4;
  logic [3:0]  st1, st4;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iter_shifter #(.WORD(16), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .operation(op), .shift(sh),
    .in(din), .status_old(sold), .busy(busy1), .done(done1),
    .out(out1), .status_new(st1)
  );

  iter_shifter #(.WORD(16), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .operation(op), .shift(sh),
    .in(din), .status_old(sold), .busy(busy4), .done(done4),
    .out(out4), .status_new(st4)
  );

  typedef struct {
    logic [15:0] o;
    logic [3:0]  s;
    int unsigned t;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: whole-count arithmetic. Rotates through C are a rotation of
  // the 17-bit value {C, data}.
  function automatic exp_t model(int step, logic [2:0] o, int n, logic [15:0] d,
                                 logic [3:0] so, int unsigned t0);
    exp_t e;
    logic [16:0] x;
    logic [15:0] r;
    logic c;
    if (n == 0 || o > 3'd4) begin
      e.o = d; e.s = so; e.t = t0 + 1;
      return e;
    end
    x = {so[0], d};
    case (o)
      3'd0: begin r = 16'($signed(d) >>> n); c = d[n-1]; end
      3'd1: begin x = (x >> n) | (x << (17 - n)); r = x[15:0]; c = x[16]; end
      3'd2: begin r = d >> n; c = d[n-1]; end
      3'd3: begin r = d << n; c = d[16-n]; end
      default: begin x = (x << n) | (x >> (17 - n)); r = x[15:0]; c = x[16]; end
    endcase
    e.o = r;
    e.s = {so[3], r[15], (r == 16'h0), c};
    e.t = t0 + 1 + int'((n + step - 1) / step);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) check("dut1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1 out", 32'(out1), 32'(e.o));
        check("dut1 status", 32'(st1), 32'(e.s));
        check("dut1 latency", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) check("dut4 unexpected done", 1, 0);
      else begin
        e = q4.pop_front();
        check("dut4 out", 32'(out4), 32'(e.o));
        check("dut4 status", 32'(st4), 32'(e.s));
        check("dut4 latency", cyc, e.t);
      end
    end
  end

  task automatic scramble();
    op   = 3'($urandom);
    sh   = 4'($urandom);
    din  = 16'($urandom);
    sold = 4'($urandom);
  endtask

  task automatic issue(bit w4, logic [2:0] o, int n, logic [15:0] d, logic [3:0] s);
    @(negedge clk);
    op = o; sh = 4'(n); din = d; sold = s;
    if (w4) begin start4 = 1'b1; q4.push_back(model(4, o, n, d, s, cyc)); end
    else    begin start1 = 1'b1; q1.push_back(model(1, o, n, d, s, cyc)); end
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    scramble();
  endtask

  // Pulse start with junk operands while the selected unit is busy.
  task automatic poke_busy(bit w4);
    @(negedge clk);
    if (w4 ? busy4 : busy1) begin
      scramble();
      if (w4) start4 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) return;
    end
    check("wait_idle timeout", 1, 0);
    q1.delete(); q4.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset busy1", 32'(busy1), 0);
    check("reset done1", 32'(done1), 0);
    check("reset out1", 32'(out1), 0);
    check("reset status1", 32'(st1), 0);
    check("reset busy4", 32'(busy4), 0);
    check("reset out4", 32'(out4), 0);
    rst = 1'b0;

    issue(0, 3'd0, 3, 16'h8001, 4'h0);  wait_idle();   // SRA
    issue(0, 3'd1, 1, 16'h0001, 4'h8);  wait_idle();   // RRC
    issue(0, 3'd4, 1, 16'h8000, 4'h1);  wait_idle();   // RLC
    issue(0, 3'd3, 2, 16'h4000, 4'h0);  wait_idle();   // SLL
    issue(0, 3'd5, 3, 16'h1234, 4'hA);  wait_idle();   // PASS
    issue(0, 3'd2, 0, 16'hBEEF, 4'h6);  wait_idle();   // n=0
    issue(1, 3'd2, 9, 16'hABCD, 4'h0);  poke_busy(1); poke_busy(1); wait_idle();
    issue(0, 3'd2, 15, 16'hFFFF, 4'h0); poke_busy(0); wait_idle();

    // Reset mid-run; a start in the reset cycle must be dropped.
    issue(0, 3'd2, 15, 16'hFFFF, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1; start1 = 1'b1; op = 3'd5; sh = 4'd0;
    @(negedge clk);
    check("rst busy1", 32'(busy1), 0);
    check("rst done1", 32'(done1), 0);
    check("rst out1", 32'(out1), 0);
    check("rst status1", 32'(st1), 0);
    q1.delete();
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("post-rst busy1", 32'(busy1), 0);
    repeat (20) @(negedge clk);
    issue(0, 3'd2, 15, 16'hFFFF, 4'h0); wait_idle();

    for (int i = 0; i < 60; i++) begin
      bit w4;
      w4 = 1'($urandom);
      issue(w4, 3'($urandom), int'($urandom_range(0, 15)), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 2) == 0) poke_busy(w4);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("dut1 queue drained", q1.size(), 0);
    check("dut4 queue drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WORD, default 16: data word width in bits, >= 4.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per cycle, 1..WORD-1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 operation  input  3  0 SRA, 1 RRC (rotate right through C), 2 SRL, 3 SLL, 4 RLC (rotate left through C), 5-7 PASS.
REQ-007 shift  input  $clog2(WORD)  shift count n, 0..WORD-1.
REQ-008 in  input  WORD  operand.
REQ-009 status_old  input  4  old flags, bit0 C, bit1 Z, bit2 N, bit3 V.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle pulse; result valid.
REQ-012 out  output  WORD  result, held until next accepted start.
REQ-013 status_new  output  4  new flags, same bit order as status_old, held with out.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start with n>0 and non-PASS op; IDLE->DONE on accepted start with n=0 or PASS; RUN->DONE on the edge where remaining count reaches 0; DONE->IDLE unconditionally.
REQ-015 Accepted start latches in, operation, shift, status_old; later input changes have no effect on the operation.
REQ-016 start while busy=1 is ignored, no queueing.
REQ-017 Each RUN cycle shifts by k = min(STEP, remaining) and decrements remaining by k.
REQ-018 Latency start-cycle to done-cycle: 1+ceil(n/STEP) cycles for n>0; 1 cycle for n=0 or PASS.
REQ-019 SRA fills MSB with sign; SRL fills with 0; SLL fills LSB with 0.
REQ-020 RRC: per bit, MSB<=C, C<=LSB; RLC: per bit, LSB<=C, C<=MSB; C carried across steps.
REQ-021 Shifts (SRA/SRL/SLL): C = last bit shifted out.
REQ-022 For n>0 non-PASS: Z = (out==0), N = out[WORD-1], V = status_old V unchanged.
REQ-023 For n=0 or PASS: out = in, status_new = status_old exactly.
REQ-024 out and status_new update only on the DONE transition; intermediate values not visible.

Reset
REQ-025 rst=1 at an edge forces IDLE, busy=0, done=0, out=0, status_new=0, remaining=0.
REQ-026 rst has priority over start; start sampled in a reset cycle is dropped.
REQ-027 Reset mid-RUN aborts without a done pulse; next start after rst deasserts is accepted normally.

Structure
REQ-028 Shared package xm_shifter_pkg holds shift_op_e (6 ops), status bit index enum (C=0, Z=1, N=2, V=3), and FSM state typedef.
REQ-029 One combinational sub-module shift_step performs a single k-bit step (op, k, data, C in -> data, C out); iter_shifter holds FSM, counter, operand/result registers.

Verification (WORD=16 unless noted)
REQ-030 STEP=1, SRA, in=0x8001, n=3, C=0 -> out=0xF000, C=0, N=1, Z=0, done 4 cycles after start.
REQ-031 STEP=1, RRC, in=0x0001, n=1, C=0, V=1 -> out=0x0000, C=1, Z=1, N=0, V=1; RLC in=0x8000, C=1, n=1 -> out=0x0001, C=1.
REQ-032 STEP=1, SLL, in=0x4000, n=2 -> out=0x0000, C=1, Z=1; PASS in=0x1234, status_old=0xA -> out=0x1234, status_new=0xA, done 1 cycle after start.
REQ-033 STEP=4, SRL, in=0xABCD, n=9 -> out=0x0055, C=1, done 4 cycles after start; start pulsed during busy ignored.
REQ-034 STEP=1, SRL, in=0xFFFF, n=15, rst at cycle 5 -> busy=0, out=0, no done; new start afterwards completes correctly.
